// File: rtl/move_cmd_ctrl_pkg.sv
// Move command codes shared by the switch front end, the command queue and
// the LOGIC consumer.
package move_cmd_ctrl_pkg;

    localparam int CMD_W = 3;

    typedef logic [CMD_W-1:0] move_cmd_t;

    localparam move_cmd_t CMD_NONE  = 3'd0;
    localparam move_cmd_t CMD_RIGHT = 3'd1;
    localparam move_cmd_t CMD_LEFT  = 3'd2;
    localparam move_cmd_t CMD_DOWN  = 3'd3;
    localparam move_cmd_t CMD_UP    = 3'd4;
    localparam move_cmd_t CMD_RESET = 3'd5;

    // Directions are the only codes that may auto-repeat.
    function automatic logic is_direction(input move_cmd_t code);
        return (code >= CMD_RIGHT) && (code <= CMD_UP);
    endfunction

endpackage

// File: rtl/move_cmd_ctrl_cmd_fifo.sv
// cmd_fifo: small synchronous FIFO, registered output (no fall-through).
// flush empties the queue; a push in the same cycle becomes the only entry
// and any pop in that cycle is ignored.
module cmd_fifo
    import move_cmd_ctrl_pkg::*;
#(
    parameter int W     = CMD_W,
    parameter int DEPTH = 4
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW-1:0] wr_addr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // A full queue still accepts a push when an entry leaves in the same cycle.
    assign do_push = push && (flush || !full || do_pop);
    assign wr_addr = flush ? '0 : wr_ptr;
    assign head    = mem[rd_ptr];
    assign level   = count;

    // Pointer and occupancy tracking; flush restarts the queue at slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? (AW+1)'(1) : '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_addr] <= push_data;
    end

endmodule

// File: rtl/move_cmd_ctrl.sv
// move_cmd_ctrl: switch levels -> queued move commands for LOGIC.
// Synchronise and debounce each switch, raise a press event on the first
// press from all-released, optionally auto-repeat held directions, and
// queue the codes behind a valid/ready handshake.
// Build option: define AUTO_REPEAT_EN to include the auto-repeat FSM.
//
// Repeat FSM (AUTO_REPEAT_EN builds only)
//   state      | meaning
//   ST_IDLE    | no direction held, waiting for a direction press event
//   ST_HOLD    | direction held, counting down REPEAT_DELAY to first repeat
//   ST_REPEAT  | direction still held, one push every REPEAT_RATE cycles
module move_cmd_ctrl
    import move_cmd_ctrl_pkg::*;
#(
    parameter int N_IN            = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int FIFO_DEPTH      = 4
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_IN-1:0]             SW,
    output logic [CMD_W-1:0]            cmd,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int              DBW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0]  DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    if (N_IN < 5 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("move_cmd_ctrl: illegal parameter combination");
    end

    logic [N_IN-1:0] sync_a;
    logic [N_IN-1:0] sync_b;
    logic [N_IN-1:0] stable;
    move_cmd_t       stable_code;
    logic [1:0]      settle_cnt;
    logic            armed;
    logic            any_prev;
    logic            press_ev;
    move_cmd_t       press_code;
    logic            rep_push;
    move_cmd_t       rep_code;
    logic            fifo_push;
    logic            fifo_flush;
    logic            fifo_pop;
    move_cmd_t       fifo_data;
    move_cmd_t       fifo_head;
    logic            fifo_empty;
    logic            fifo_full;

    // Two-flop synchroniser on every raw switch bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= SW;
            sync_b <= sync_a;
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_db
        logic [DBW-1:0] db_cnt;
        logic           db_bit;

        // Stable bit flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
        always_ff @(posedge clk) begin
            if (rst) begin
                db_cnt <= '0;
                db_bit <= 1'b0;
            end else if (sync_b[i] == db_bit) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                db_bit <= ~db_bit;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end
        end

        assign stable[i] = db_bit;
    end

    // Highest-priority code among the debounced switches.
    always_comb begin
        stable_code = CMD_NONE;
        if      (stable[0])      stable_code = CMD_RIGHT;
        else if (stable[1])      stable_code = CMD_LEFT;
        else if (stable[2])      stable_code = CMD_DOWN;
        else if (stable[3])      stable_code = CMD_UP;
        else if (stable[N_IN-1]) stable_code = CMD_RESET;
    end

    // After reset, wait for the synchroniser to refill and every switch to be
    // seen released, so a switch held through reset cannot fire an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= 2'd0;
            armed      <= 1'b0;
        end else begin
            if (settle_cnt != 2'd2) settle_cnt <= settle_cnt + 2'd1;
            if (settle_cnt == 2'd2 && sync_b == '0 && stable == '0) armed <= 1'b1;
        end
    end

    // Registered press event: something pressed now, nothing pressed last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_prev   <= 1'b0;
            press_ev   <= 1'b0;
            press_code <= CMD_NONE;
        end else begin
            any_prev   <= |stable;
            press_ev   <= armed && (|stable) && !any_prev;
            press_code <= stable_code;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [1:0]  rep_state;
    move_cmd_t   held_code;
    logic [31:0] rep_timer;
    logic        held_live;

    // Held direction still down and nothing of higher priority joined it.
    always_comb begin
        held_live = 1'b0;
        case (held_code)
            CMD_RIGHT: held_live = stable[0];
            CMD_LEFT:  held_live = stable[1] && !stable[0];
            CMD_DOWN:  held_live = stable[2] && !(|stable[1:0]);
            CMD_UP:    held_live = stable[3] && !(|stable[2:0]);
            default:   held_live = 1'b0;
        endcase
    end

    assign rep_push = (rep_state != ST_IDLE) && held_live && (rep_timer == '0);
    assign rep_code = held_code;

    // Repeat sequencing with a down-counter and terminal-count compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_state <= ST_IDLE;
            held_code <= CMD_NONE;
            rep_timer <= '0;
        end else begin
            case (rep_state)
                ST_IDLE: begin
                    if (press_ev && is_direction(press_code)) begin
                        rep_state <= ST_HOLD;
                        held_code <= press_code;
                        rep_timer <= 32'(REPEAT_DELAY - 1);
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (!held_live) begin
                        rep_state <= ST_IDLE;
                    end else if (rep_timer == '0) begin
                        rep_state <= ST_REPEAT;
                        rep_timer <= 32'(REPEAT_RATE - 1);
                    end else begin
                        rep_timer <= rep_timer - 32'd1;
                    end
                end
                default: rep_state <= ST_IDLE;
            endcase
        end
    end
`else
    assign rep_push = 1'b0;
    assign rep_code = CMD_NONE;
`endif

    assign fifo_flush = press_ev && (press_code == CMD_RESET);
    assign fifo_push  = (press_ev && (press_code != CMD_NONE)) || rep_push;
    assign fifo_data  = press_ev ? press_code : rep_code;
    assign fifo_pop   = cmd_valid && cmd_ready;

    cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (fifo_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level)
    );

    assign cmd_valid = !fifo_empty;
    assign cmd       = fifo_empty ? CMD_NONE : fifo_head;

    // Sticky drop flag; a RESET flush always has room, so it never sets this.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (fifo_push && !fifo_flush && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_move_cmd_ctrl.sv
// Bench for move_cmd_ctrl with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
// Expected commands go into a scoreboard queue when a press is driven and
// are popped whenever the DUT completes a valid/ready handshake.
module tb_move_cmd_ctrl;

    localparam int DB = 4;
    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_RIGHT = 3'd1;
    localparam logic [2:0] C_LEFT  = 3'd2;
    localparam logic [2:0] C_DOWN  = 3'd3;
    localparam logic [2:0] C_UP    = 3'd4;
    localparam logic [2:0] C_RESET = 3'd5;
`ifdef AUTO_REPEAT_EN
    localparam int N_REP = 5;
`else
    localparam int N_REP = 1;
`endif

    typedef struct {
        string       name;
        logic [15:0] sw;
        logic [2:0]  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] SW;
    logic [2:0]  cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        overflow;
    logic [2:0]  level;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [2:0]  exp_q[$];
    int          pop_times[$];
    vec_t        tbl[12];
    int          exp_delta[5] = '{0, 20, 25, 30, 35};

    move_cmd_ctrl #(
        .N_IN            (16),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (5),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SW        (SW),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Score the handshake about to happen, then advance one clock to the next negedge.
    task automatic step();
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            pop_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pop: got cmd %0d, want no command (cycle %0d)", cmd, cyc);
            end else begin
                chk("pop_cmd", int'(cmd), int'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic press(input logic [15:0] pat, input int hold, input int gap);
        SW = pat;
        steps(hold);
        SW = '0;
        steps(gap);
    endtask

    initial begin
        tbl[0]  = '{"right",       16'h0001, C_RIGHT};
        tbl[1]  = '{"left",        16'h0002, C_LEFT};
        tbl[2]  = '{"down",        16'h0004, C_DOWN};
        tbl[3]  = '{"up",          16'h0008, C_UP};
        tbl[4]  = '{"down_up",     16'h000C, C_DOWN};
        tbl[5]  = '{"up_after",    16'h0008, C_UP};
        tbl[6]  = '{"left_up",     16'h000A, C_LEFT};
        tbl[7]  = '{"reset",       16'h8000, C_RESET};
        tbl[8]  = '{"up_reset",    16'h8008, C_UP};
        tbl[9]  = '{"other",       16'h0010, C_NONE};
        tbl[10] = '{"others",      16'h0110, C_NONE};
        tbl[11] = '{"all",         16'hFFFF, C_RIGHT};

        rst = 1'b1;
        SW = '0;
        cmd_ready = 1'b0;
        steps(3);
        chk("rst_cmd",   int'(cmd), int'(C_NONE));
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_ovf",   int'(overflow), 0);
        chk("rst_level", int'(level), 0);
        rst = 1'b0;
        steps(4);

        // Clean rise on SW[0]: valid exactly 2+DB+2 cycles later, no fall-through.
        SW = 16'h0001;
        exp_q.push_back(C_RIGHT);
        steps(DB + 3);
        chk("lat_early_valid", int'(cmd_valid), 0);
        step();
        chk("lat_valid", int'(cmd_valid), 1);
        chk("lat_cmd",   int'(cmd), int'(C_RIGHT));
        chk("lat_level", int'(level), 1);
        steps(4);
        SW = '0;
        steps(12);
        chk("hold_level", int'(level), 1);
        chk("hold_cmd",   int'(cmd), int'(C_RIGHT));
        cmd_ready = 1'b1;
        step();
        chk("pop_level", int'(level), 0);

        // Glitches shorter than the debounce window never produce a command.
        for (int g = 0; g < 3; g++) press(16'h0002, 3, 3);
        steps(10);
        chk("glitch_level", int'(level), 0);
        exp_q.push_back(C_LEFT);
        press(16'h0002, 10, 14);
        chk("glitch_drain", exp_q.size(), 0);

        // Priority table, consumer always ready.
        for (int v = 0; v < 12; v++) begin
            if (tbl[v].exp != C_NONE) exp_q.push_back(tbl[v].exp);
            press(tbl[v].sw, DB + 8, DB + 8);
            chk({"tbl_", tbl[v].name}, exp_q.size(), 0);
        end
        chk("tbl_level", int'(level), 0);
        chk("tbl_ovf",   int'(overflow), 0);

        // Overflow: five presses into a four-deep queue.
        cmd_ready = 1'b0;
        for (int p = 0; p < 5; p++) begin
            if (p < 4) exp_q.push_back(C_RIGHT);
            press(16'h0001, 10, 10);
        end
        chk("ovf_level", int'(level), 4);
        chk("ovf_flag",  int'(overflow), 1);
        // Pop and push in the same cycle while full.
        SW = 16'h0002;
        exp_q.push_back(C_LEFT);
        steps(DB + 3);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("poppush_level", int'(level), 4);
        steps(3);
        SW = '0;
        steps(10);
        chk("poppush_level2", int'(level), 4);
        chk("poppush_ovf",    int'(overflow), 1);
        cmd_ready = 1'b1;
        steps(8);
        chk("ovf_drain", exp_q.size(), 0);
        chk("ovf_drain_level", int'(level), 0);

        // RESET flushes the queue; a pop in the flush cycle is ignored.
        cmd_ready = 1'b0;
        exp_q.push_back(C_RIGHT);
        press(16'h0001, 10, 10);
        exp_q.push_back(C_LEFT);
        press(16'h0002, 10, 10);
        exp_q.push_back(C_DOWN);
        press(16'h0004, 10, 10);
        chk("pre_reset_level", int'(level), 3);
        SW = 16'h8000;
        steps(DB + 3);
        chk("flush_wait_level", int'(level), 3);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("flush_level", int'(level), 1);
        chk("flush_cmd",   int'(cmd), int'(C_RESET));
        chk("flush_ovf",   int'(overflow), 1);
        exp_q.delete();
        exp_q.push_back(C_RESET);
        SW = '0;
        cmd_ready = 1'b1;
        steps(10);
        chk("flush_drain", exp_q.size(), 0);

        // Held direction: repeats only when the auto-repeat FSM is built.
        pop_times.delete();
        for (int r = 0; r < N_REP; r++) exp_q.push_back(C_RIGHT);
        press(16'h0001, 40, 30);
        chk("rep_count", pop_times.size(), N_REP);
        for (int k = 1; k < N_REP && k < pop_times.size(); k++)
            chk("rep_delta", pop_times[k] - pop_times[0], exp_delta[k]);
        chk("rep_drain", exp_q.size(), 0);

        // rst mid-hold discards the queue; nothing more until released.
        cmd_ready = 1'b0;
        SW = 16'h0001;
        steps(12);
        chk("midrst_pre_level", int'(level), 1);
        rst = 1'b1;
        step();
        chk("midrst_valid", int'(cmd_valid), 0);
        chk("midrst_level", int'(level), 0);
        chk("midrst_cmd",   int'(cmd), int'(C_NONE));
        chk("midrst_ovf",   int'(overflow), 0);
        exp_q.delete();
        rst = 1'b0;
        cmd_ready = 1'b1;
        steps(40);
        chk("midrst_held_level", int'(level), 0);
        SW = '0;
        steps(12);
        exp_q.push_back(C_LEFT);
        press(16'h0002, 10, 12);
        chk("midrst_rearm", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/move_cmd_ctrl.md
Name: move_cmd_ctrl

Overview:
Parametrised successor to the top-level switch-to-move logic. It converts raw switch levels into a queued stream of game move commands for LOGIC. Each switch is synchronised and debounced. The block keeps the "first press from all-released" chord rule and adds optional auto-repeat on held directions. Commands are buffered in a FIFO and handed to the consumer over a valid/ready handshake, replacing the previous one-cycle `move` pulse. Sits between the board switches and LOGIC in the 100 MHz `clk` domain.

Parameters:
N_IN, 16, switch input width; bits 0..3 are RIGHT/LEFT/DOWN/UP, bit N_IN-1 is RESET, other bits only count toward "any pressed".
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a debounced bit changes (>=1).
REPEAT_DELAY, 50000000, held cycles before the first repeat.
REPEAT_RATE, 10000000, cycles between subsequent repeats (>=1).
FIFO_DEPTH, 4, command queue entries (power of 2, >=2).

Ports:
clk  in  1  system clock, 100 MHz, all logic on posedge.
rst  in  1  synchronous, active-high reset.
SW  in  N_IN  raw asynchronous switch levels.
cmd  out  3  head-of-queue move code (package constants).
cmd_valid  out  1  cmd holds a valid command.
cmd_ready  in  1  consumer accepts cmd this cycle when cmd_valid=1.
overflow  out  1  sticky: a command was dropped because the FIFO was full.
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: rst is sampled on posedge clk. It clears synchronisers, debounced state (all 0), counters, FIFO, and the repeat state.
  - Reset values: cmd=NONE, cmd_valid=0, overflow=0, level=0.
  - rst mid-operation discards queued commands immediately. Held switches do not emit an event until all bits have been debounced low again.
- Sync: 2-FF synchroniser per bit.
- Debounce: per-bit counter.
  - While the synced bit differs from the stable bit, the counter increments. It resets to 0 on any cycle where they agree.
  - When the count reaches DEBOUNCE_CYCLES, the stable bit toggles and the counter clears.
- Press event (registered):
  - Fires when any stable bit is 1 in this cycle and all stable bits were 0 in the previous cycle.
  - Code priority: RIGHT(bit0) > LEFT(1) > DOWN(2) > UP(3) > RESET(N_IN-1).
  - If only "other" bits are set, no command is produced and the rule stays armed until all bits are released.
- Latency: a clean SW edge gives cmd_valid high 2+DEBOUNCE_CYCLES+2 cycles later, with the FIFO empty.
- Repeat FSM (IDLE, HOLD, REPEAT):
  - IDLE→HOLD on a direction press event; the held code is latched.
  - In HOLD, after REPEAT_DELAY cycles, push the held code and go to REPEAT.
  - In REPEAT, push every REPEAT_RATE cycles.
  - Any cycle where the stable held bit is 0, or a higher-priority bit becomes 1, returns to IDLE with no push that cycle.
  - RESET never repeats.
- FIFO:
  - Pop occurs when cmd_valid && cmd_ready.
  - A push to an empty FIFO becomes visible on the next cycle (no fall-through).
  - Full with no pop: the push is dropped and overflow is set.
  - Full with a simultaneous pop: the push is accepted and level is unchanged.
  - Empty: cmd=NONE, and cmd_ready is ignored.
- RESET command: flushes all queued entries and enqueues RESET alone; next cycle level=1 and cmd=RESET. A pop in the same cycle is ignored. A RESET push never sets overflow.

Optional Feature:
AUTO_REPEAT_EN.
- Defined: repeat FSM is present as described.
- Undefined: FSM and counters are not built. Exactly one command is produced per press event, and REPEAT_DELAY/REPEAT_RATE are unused.

Decomposition:
- PARAMS.v holds the move codes NONE=3'd0, RIGHT=3'd1, LEFT=3'd2, DOWN=3'd3, UP=3'd4, RESET=3'd5, plus CMD_W=3.
- One natural sub-module: cmd_fifo (synchronous FIFO parametrised by width and depth, with a flush input).
- Debounce is instantiated per bit in a generate loop inside move_cmd_ctrl.

Test Plan:
- DEBOUNCE_CYCLES=4, AUTO_REPEAT_EN off, SW[0] rises cleanly, cmd_ready=0 → cmd_valid=1 and cmd=RIGHT exactly 8 cycles later, level=1, held steady with no repeat.
- SW[1] toggles glitch-style 3-cycle pulses with DEBOUNCE_CYCLES=4 → no command ever; then SW[1] held 10 cycles → one LEFT.
- SW[2] and SW[3] rise together → only DOWN; release both, press SW[3] → UP.
- FIFO_DEPTH=4, cmd_ready=0, 5 separate presses → level=4, overflow=1, the fifth is lost. Then a pop with a simultaneous press → level stays 4.
- 3 directions queued, press SW[15] → next cycle level=1, cmd=RESET, overflow unchanged.
- AUTO_REPEAT_EN on, REPEAT_DELAY=20, REPEAT_RATE=5, cmd_ready=1, SW[0] held 40 cycles past debounce → RIGHT at 0, 20, 25, 30, 35 cycles. Asserting rst mid-hold → cmd_valid=0 next cycle and no further commands until release.
